// File: rtl/npu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// npu_pkg : shared NPU types/constants for runtime-loadable units.  Rev 1.0
// ---------------------------------------------------------------------------
package npu_pkg;

  localparam int ACT_LUT_DW      = 32;
  localparam int ACT_LUT_SAMPLES = 512;

  // Load sequencing shared by every loadable table unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } load_state_e;

endpackage
`default_nettype wire

// File: rtl/act_lut_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// act_lut_ram : simple dual-port table, registered read address and output.
// Rev 1.0
// ---------------------------------------------------------------------------
module act_lut_ram
  import npu_pkg::*;
#(
  parameter int DW      = ACT_LUT_DW,
  parameter int SAMPLES = ACT_LUT_SAMPLES,
  parameter int AW      = $clog2(SAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [SAMPLES];
  logic [AW-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr;
  end

  // Same-edge write is not visible here, giving old-data read-during-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr_q];
    end
  end

endmodule
`default_nettype wire

// File: rtl/act_lut_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// act_lut_loader : stream-loadable activation LUT with 2-clock lookup port.
// Optional macro ACT_LUT_CHECKSUM_EN enables the XOR load checksum.  Rev 1.0
// ---------------------------------------------------------------------------
module act_lut_loader
  import npu_pkg::*;
#(
  parameter int DW      = ACT_LUT_DW,
  parameter int SAMPLES = ACT_LUT_SAMPLES,
  parameter int AW      = $clog2(SAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          busy,
  output logic          ld_done,
  output logic          ld_err,
  output logic          table_valid,
  input  logic [AW-1:0] lut_rd_addr,
  output logic [DW-1:0] lut_rd_data,
  output logic [DW-1:0] lut_checksum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLES - 1);

  load_state_e   state;
  load_state_e   state_next;
  logic [AW-1:0] wr_ptr;
  logic          beat;
  logic          at_end;
  logic          start_load;

  // ld_ready is exactly (state == LOAD), so the handshake is decoded directly.
  assign beat       = ld_valid && (state == LOAD);
  assign at_end     = (wr_ptr == LAST_ADDR);
  assign start_load = (state == IDLE) && load_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    ld_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid && (ld_last || at_end)) begin
          state_next = FIN;
        end
      end
      FIN: begin
        busy       = 1'b1;
        ld_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      ld_err      <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      if (start_load) begin
        wr_ptr      <= '0;
        ld_err      <= 1'b0;
        table_valid <= 1'b0;
      end
      if (beat) begin
        if (!at_end) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        // Short load (last before the end) or overrun (end without last).
        if (ld_last != at_end) begin
          ld_err <= 1'b1;
        end
      end
      if (state == FIN) begin
        table_valid <= !ld_err;
      end
    end
  end

`ifdef ACT_LUT_CHECKSUM_EN
  logic [DW-1:0] checksum;

  // Result is captured on the final beat so it is stable alongside ld_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum     <= '0;
      lut_checksum <= '0;
    end else if (start_load) begin
      checksum     <= '0;
      lut_checksum <= '0;
    end else if (beat) begin
      checksum <= checksum ^ ld_data;
      if (ld_last || at_end) begin
        lut_checksum <= checksum ^ ld_data;
      end
    end
  end
`else
  assign lut_checksum = '0;
`endif

  act_lut_ram #(
    .DW      (DW),
    .SAMPLES (SAMPLES),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (beat),
    .wr_addr (wr_ptr),
    .wr_data (ld_data),
    .rd_addr (lut_rd_addr),
    .rd_data (lut_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_act_lut_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_act_lut_loader : randomized self-checking bench against a table model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_act_lut_loader;

  localparam int DW      = 32;
  localparam int SAMPLES = 512;
  localparam int AW      = 9;

`ifdef ACT_LUT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          load_start;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_last;
  logic          ld_ready;
  logic          busy;
  logic          ld_done;
  logic          ld_err;
  logic          table_valid;
  logic [AW-1:0] lut_rd_addr;
  logic [DW-1:0] lut_rd_data;
  logic [DW-1:0] lut_checksum;

  logic [DW-1:0] stim    [SAMPLES+1];
  logic [DW-1:0] exp_mem [SAMPLES];
  int checks   = 0;
  int failures = 0;

  act_lut_loader #(.DW(DW), .SAMPLES(SAMPLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .busy         (busy),
    .ld_done      (ld_done),
    .ld_err       (ld_err),
    .table_valid  (table_valid),
    .lut_rd_addr  (lut_rd_addr),
    .lut_rd_data  (lut_rd_data),
    .lut_checksum (lut_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ld_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, ld_done, 0);
    check({tag, "_err"}, ld_err, 0);
    check({tag, "_tv"}, table_valid, 0);
    check({tag, "_rdata"}, lut_rd_data, 0);
    check({tag, "_csum"}, lut_checksum, 0);
  endtask

  // Streams stim[] into the DUT; last_at<0 means ld_last is never raised.
  task automatic run_load(input int n, input int last_at, input int gap_pct, input bit mid_start);
    int          accepted;
    int          exp_acc;
    int          cyc;
    int          done_cnt;
    bit          finished;
    bit          exp_err;
    logic [31:0] csum;
    exp_acc = (last_at >= 0 && last_at < SAMPLES) ? last_at + 1 : SAMPLES;
    exp_err = (last_at != SAMPLES - 1);
    csum = 0;
    for (int k = 0; k < exp_acc; k++) csum ^= stim[k];

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_ready", ld_ready, 1);
    check("start_busy", busy, 1);
    check("start_err", ld_err, 0);
    check("start_tv", table_valid, 0);

    accepted = 0; cyc = 0; finished = 0; done_cnt = 0;
    while (!finished && cyc < 5000) begin
      ld_valid   = (accepted < n) && ($urandom_range(99) >= gap_pct);
      ld_data    = stim[accepted];
      ld_last    = (accepted == last_at);
      load_start = mid_start && (cyc == 37);
      if (ld_valid && ld_ready) accepted++;
      tick();
      cyc++;
      load_start = 1'b0;
      if (ld_done) begin
        done_cnt++;
        finished = 1;
      end
    end
    check("load_timeout", finished, 1);
    check("done_count", done_cnt, 1);
    check("accepted", accepted, exp_acc);
    check("fin_ready", ld_ready, 0);
    check("fin_busy", busy, 1);
    check("fin_err", ld_err, exp_err);
    check("fin_csum", lut_checksum, CSUM_EN ? csum : 32'h0);

    // Keep offering a further word; it must never be taken.
    ld_valid = 1'b1;
    ld_data  = stim[accepted];
    ld_last  = 1'b0;
    tick();
    check("post_done", ld_done, 0);
    check("post_busy", busy, 0);
    check("post_ready", ld_ready, 0);
    check("post_tv", table_valid, !exp_err);
    check("post_err", ld_err, exp_err);
    tick();
    ld_valid = 1'b0;
    for (int k = 0; k < exp_acc; k++) exp_mem[k] = stim[k];
  endtask

  // Pipelined reads: data for an address is checked two edges after it is driven.
  task automatic read_check(input int count, input bit seq);
    int a;
    int prev;
    prev = 0;
    for (int j = 0; j <= count; j++) begin
      a = seq ? (j % SAMPLES) : int'($urandom_range(SAMPLES - 1));
      lut_rd_addr = a[AW-1:0];
      tick();
      if (j > 0) check("rd_data", lut_rd_data, exp_mem[prev]);
      prev = a;
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; ld_data = '0; ld_valid = 1'b0;
    ld_last = 1'b0; lut_rd_addr = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Good load with the ramp pattern, then targeted and full-table reads.
    for (int k = 0; k <= SAMPLES; k++) stim[k] = 32'h0000_1000 + k;
    run_load(SAMPLES, SAMPLES - 1, 0, 1'b0);
    lut_rd_addr = 9'd5;
    tick();
    lut_rd_addr = 9'd7;
    tick();
    check("rd_addr5_lat2", lut_rd_data, 32'h0000_1005);
    tick();
    check("rd_addr7_lat2", lut_rd_data, 32'h0000_1007);
    read_check(SAMPLES, 1'b1);

    // Short load: ld_last on the tenth word.
    for (int k = 0; k <= SAMPLES; k++) stim[k] = $urandom;
    run_load(SAMPLES, 9, 20, 1'b0);

    // Overrun: 513 words offered without ld_last.
    for (int k = 0; k <= SAMPLES; k++) stim[k] = $urandom;
    run_load(SAMPLES + 1, -1, 10, 1'b0);

    // Alternating-ish gaps plus an ignored load_start mid-stream.
    for (int k = 0; k <= SAMPLES; k++) stim[k] = $urandom;
    run_load(SAMPLES, SAMPLES - 1, 50, 1'b1);
    read_check(200, 1'b0);

    // Reset mid-load after 100 words.
    for (int k = 0; k <= SAMPLES; k++) stim[k] = $urandom;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      ld_valid = 1'b1;
      ld_data  = stim[k];
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    for (int k = 0; k <= SAMPLES; k++) stim[k] = $urandom;
    run_load(SAMPLES, SAMPLES - 1, 30, 1'b0);
    read_check(200, 1'b0);

    // Checksum patterns.
    for (int k = 0; k <= SAMPLES; k++) stim[k] = 32'hA5A5_A5A5;
    run_load(SAMPLES, SAMPLES - 1, 0, 1'b0);
    check("csum_hold_a5", lut_checksum, CSUM_EN ? 32'h0000_0000 : 32'h0);
    stim[0] = 32'h0000_0001;
    run_load(SAMPLES, SAMPLES - 1, 25, 1'b0);
    check("csum_hold_a4", lut_checksum, CSUM_EN ? 32'hA5A5_A5A4 : 32'h0);
    read_check(64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
